// File: rtl/aes_pkg.sv
// Shared AES constants and the serializer state encodings.
package aes_pkg;

  localparam int AES_BLOCK_BITS  = 128;
  localparam int AES_BLOCK_BYTES = 16;

  localparam logic [0:0] SER_IDLE = 1'b0;
  localparam logic [0:0] SER_SEND = 1'b1;

endpackage

// File: rtl/aes_cipher_serializer.sv
// Captures a finished AES block on the rising edge of the core's done level
// and streams it out MSB byte first over a byte-wide valid/ready port.
module aes_cipher_serializer
  import aes_pkg::*;
#(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [0:127]           i_cipher,
  input  logic                   i_is_done,
  output logic [0:7]             o_byte,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_last,
  output logic                   o_busy,
  output logic                   o_overrun,
  output logic [COUNT_WIDTH-1:0] o_block_count
);

  // state | meaning
  // IDLE  | waiting for a rising edge of i_is_done
  // SEND  | presenting r_buf head, one byte per handshake

  localparam logic [3:0] LAST_IDX = 4'(AES_BLOCK_BYTES - 1);

  logic                      r_done_d;
  logic [0:AES_BLOCK_BITS-1] r_buf;
  logic [3:0]                r_idx;
  logic [0:0]                r_state;
  logic                      r_overrun;
  logic [COUNT_WIDTH-1:0]    r_count;

  logic w_rise;
  logic w_send;
  logic w_hs;
  logic w_end;

  assign w_rise = i_is_done & ~r_done_d;
  assign w_send = (r_state == SER_SEND);
  assign w_hs   = w_send & i_ready;
  assign w_end  = w_hs & (r_idx == LAST_IDX);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_done_d  <= 1'b0;
      r_buf     <= '0;
      r_idx     <= '0;
      r_state   <= SER_IDLE;
      r_overrun <= 1'b0;
      r_count   <= '0;
    end else begin
      r_done_d <= i_is_done;
      if (!w_send) begin
        if (w_rise) begin
          r_buf   <= i_cipher;
          r_idx   <= '0;
          r_state <= SER_SEND;
        end
      end else begin
        if (w_end) begin
          r_count <= r_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
          // A rise landing on the final handshake chains straight into the next block.
          if (w_rise) begin
            r_buf <= i_cipher;
            r_idx <= '0;
          end else begin
            r_state <= SER_IDLE;
          end
        end else if (w_hs) begin
          r_buf <= r_buf << 8;
          r_idx <= r_idx + 4'd1;
        end
        if (w_rise && !w_end) begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign o_byte        = r_buf[0:7];
  assign o_valid       = w_send;
  assign o_last        = w_send & (r_idx == LAST_IDX);
  assign o_busy        = w_send;
  assign o_overrun     = r_overrun;
  assign o_block_count = r_count;

endmodule
